// File: rtl/wb_march_pkg.sv
// Shared types and helpers for the Wishbone SRAM March self-test master.
package wb_march_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    GAP   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } sweep_e;

  localparam logic [3:0]  SEL_ALL       = 4'hF;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

  // Test pattern for a word: seed xor index, optionally complemented.
  function automatic logic [31:0] pat(input logic [31:0] seed,
                                      input logic [31:0] idx,
                                      input logic        inv);
    logic [31:0] p;
    p = seed ^ idx;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/wb_single_access.sv
// One Wishbone classic access: drives the bus from a launch pulse until the
// first ack (or until the ack-wait counter expires), then releases it.
module wb_single_access
  import wb_march_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  input  logic [31:0] wb_dat_rd,
  input  logic        wb_ack,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat,
  output logic [3:0]  wb_sel,
  output logic [31:0] rdata,
  output logic        acc_done,
  output logic        acc_timeout
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic        cyc_r;
  logic        we_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;
  logic [3:0]  sel_r;
  logic [31:0] rdata_r;
  logic [7:0]  wait_cnt_r;
  logic        ack_s;
  logic        expire_s;

  // Acks only count while a cycle is open; expiry is the last unacked wait cycle.
  always_comb begin
    ack_s    = cyc_r & wb_ack;
    expire_s = cyc_r & ~wb_ack & (wait_cnt_r == WAIT_LAST);
  end

  // Bus request register: launch, hold until ack/expiry, then release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      adr_r      <= 32'h0;
      dat_r      <= 32'h0;
      sel_r      <= 4'h0;
      wait_cnt_r <= 8'h0;
    end else if (go) begin
      cyc_r      <= 1'b1;
      we_r       <= we;
      adr_r      <= adr;
      dat_r      <= we ? wdat : 32'h0;
      sel_r      <= SEL_ALL;
      wait_cnt_r <= 8'h0;
    end else if (ack_s || expire_s) begin
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      adr_r      <= 32'h0;
      dat_r      <= 32'h0;
      sel_r      <= 4'h0;
      wait_cnt_r <= 8'h0;
    end else if (cyc_r) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end

  // Read data is captured in the ack cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= 32'h0;
    end else if (ack_s) begin
      rdata_r <= wb_dat_rd;
    end
  end

  assign wb_cyc      = cyc_r;
  assign wb_stb      = cyc_r;
  assign wb_we       = we_r;
  assign wb_adr      = adr_r;
  assign wb_dat      = dat_r;
  assign wb_sel      = sel_r;
  assign rdata       = rdata_r;
  assign acc_done    = ack_s;
  assign acc_timeout = expire_s;

endmodule

// File: rtl/wb_sram_march_master.sv
// March C- style self-test initiator for the user-area Wishbone SRAM.
// Sweeps: S0 up write P, S1 up read P / write ~P, S2 down read ~P.
module wb_sram_march_master
  import wb_march_pkg::*;
#(
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned IDX_W    = $clog2(WORDS)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      seed_i,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic             m_we_o,
  output logic [31:0]      m_adr_o,
  output logic [31:0]      m_dat_o,
  output logic [3:0]       m_sel_o,
  input  logic [31:0]      m_dat_i,
  input  logic             m_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [15:0]      err_cnt_o,
  output logic [IDX_W-1:0] fail_idx_o,
  output logic [31:0]      fail_rd_o,
  output logic [31:0]      fail_exp_o
);

  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  state_e           state_r, state_nx_s;
  sweep_e           sweep_r, sweep_nx_s;
  logic             phase_r, phase_nx_s;   // S1 only: 0 = read, 1 = write
  logic [IDX_W-1:0] idx_r, idx_nx_s;
  logic [31:0]      seed_r, seed_nx_s;
  logic             go_s, start_ok_s, fin_s, rd_op_s, mismatch_s, launch_we_s;
  logic [31:0]      launch_adr_s, launch_dat_s, exp_s, rdata_s;
  logic             acc_done_s, acc_to_s;

  logic             busy_r, done_r, pass_r, timeout_r;
  logic [15:0]      err_cnt_r;
  logic [IDX_W-1:0] fail_idx_r;
  logic [31:0]      fail_rd_r, fail_exp_r;

  wb_single_access #(.TIMEOUT(TIMEOUT)) u_acc (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_n_i),
    .go          (go_s),
    .we          (launch_we_s),
    .adr         (launch_adr_s),
    .wdat        (launch_dat_s),
    .wb_dat_rd   (m_dat_i),
    .wb_ack      (m_ack_i),
    .wb_cyc      (m_cyc_o),
    .wb_stb      (m_stb_o),
    .wb_we       (m_we_o),
    .wb_adr      (m_adr_o),
    .wb_dat      (m_dat_o),
    .wb_sel      (m_sel_o),
    .rdata       (rdata_s),
    .acc_done    (acc_done_s),
    .acc_timeout (acc_to_s)
  );

  // Decode the current operation and what a read of it should return.
  always_comb begin
    rd_op_s    = (sweep_r == S2) || ((sweep_r == S1) && !phase_r);
    exp_s      = pat(seed_r, 32'(idx_r), sweep_r == S2);
    mismatch_s = (rdata_s != exp_s);
  end

  // Next-state logic and sweep/index sequencing.
  always_comb begin
    state_nx_s = state_r;
    sweep_nx_s = sweep_r;
    phase_nx_s = phase_r;
    idx_nx_s   = idx_r;
    seed_nx_s  = seed_r;
    go_s       = 1'b0;
    start_ok_s = 1'b0;
    fin_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_nx_s = REQ;
          go_s       = 1'b1;
          start_ok_s = 1'b1;
          sweep_nx_s = S0;
          phase_nx_s = 1'b0;
          idx_nx_s   = IDX_ZERO;
          seed_nx_s  = seed_i;
        end else begin
          state_nx_s = state_r;
        end
      end
      REQ: begin
        if (acc_done_s) begin
          state_nx_s = rd_op_s ? CHECK : GAP;
        end else if (acc_to_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = REQ;
        end
      end
      CHECK: state_nx_s = GAP;
      GAP: begin
        go_s       = 1'b1;
        state_nx_s = REQ;
        case (sweep_r)
          S0: begin
            if (idx_r == IDX_MAX) begin
              sweep_nx_s = S1;
              idx_nx_s   = IDX_ZERO;
              phase_nx_s = 1'b0;
            end else begin
              idx_nx_s = idx_r + IDX_W'(1);
            end
          end
          S1: begin
            if (!phase_r) begin
              phase_nx_s = 1'b1;
            end else if (idx_r == IDX_MAX) begin
              sweep_nx_s = S2;
              idx_nx_s   = IDX_MAX;
              phase_nx_s = 1'b0;
            end else begin
              idx_nx_s   = idx_r + IDX_W'(1);
              phase_nx_s = 1'b0;
            end
          end
          S2: begin
            if (idx_r == IDX_ZERO) begin
              go_s       = 1'b0;
              fin_s      = 1'b1;
              state_nx_s = DONE;
            end else begin
              idx_nx_s = idx_r - IDX_W'(1);
            end
          end
          default: begin
            go_s       = 1'b0;
            fin_s      = 1'b1;
            state_nx_s = DONE;
          end
        endcase
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Fields of the access launched with go_s.
  always_comb begin
    launch_we_s  = (sweep_nx_s == S0) || ((sweep_nx_s == S1) && phase_nx_s);
    launch_adr_s = BASE_ADDR + (32'(idx_nx_s) << 2);
    launch_dat_s = pat(seed_nx_s, 32'(idx_nx_s), sweep_nx_s == S1);
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Sequencer position and seed, updated whenever an access is launched.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      sweep_r <= S0;
      phase_r <= 1'b0;
      idx_r   <= IDX_ZERO;
      seed_r  <= 32'h0;
    end else if (go_s) begin
      sweep_r <= sweep_nx_s;
      phase_r <= phase_nx_s;
      idx_r   <= idx_nx_s;
      seed_r  <= seed_nx_s;
    end
  end

  // Test status: cleared on start, updated by checks, finalised on DONE entry.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i || start_ok_s) begin
      busy_r     <= wb_rst_n_i;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      err_cnt_r  <= 16'h0;
      fail_idx_r <= IDX_ZERO;
      fail_rd_r  <= 32'h0;
      fail_exp_r <= 32'h0;
    end else if (acc_to_s) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b1;
      pass_r    <= 1'b0;
      timeout_r <= 1'b1;
    end else if (fin_s) begin
      busy_r <= 1'b0;
      done_r <= 1'b1;
      pass_r <= (err_cnt_r == 16'h0) && !timeout_r;
    end else if ((state_r == CHECK) && mismatch_s) begin
      if (err_cnt_r != 16'hFFFF) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
      if (err_cnt_r == 16'h0) begin
        fail_idx_r <= idx_r;
        fail_rd_r  <= rdata_s;
        fail_exp_r <= exp_s;
      end
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign pass_o     = pass_r;
  assign timeout_o  = timeout_r;
  assign err_cnt_o  = err_cnt_r;
  assign fail_idx_o = fail_idx_r;
  assign fail_rd_o  = fail_rd_r;
  assign fail_exp_o = fail_exp_r;

endmodule

// File: tb/tb_wb_sram_march_master.sv
// Self-checking bench for wb_sram_march_master with a behavioural SRAM responder.
module tb_wb_sram_march_master;

  logic        clk = 1'b0;
  logic        rst_n, start_i;
  logic [31:0] seed_i;
  logic        cyc, stb, we, ack, busy, done, pass, tmo;
  logic [31:0] adr, dat_o, dat_i, frd, fexp;
  logic [3:0]  sel;
  logic [15:0] err;
  logic [9:0]  fidx;

  int          n_vec, n_err;
  int          ws, wcnt;
  bit          never_ack, stuck;
  logic [31:0] mem [1024];
  logic [64:0] exp_q[$];
  logic [64:0] act_q[$];
  int          e_err, busy_cycles, cyc_high, prot;
  logic [9:0]  e_fidx;
  logic [31:0] e_frd, e_fexp, seed;
  int          k, nack;

  always #5 clk = ~clk;

  wb_sram_march_master dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .start_i    (start_i),
    .seed_i     (seed_i),
    .m_cyc_o    (cyc),
    .m_stb_o    (stb),
    .m_we_o     (we),
    .m_adr_o    (adr),
    .m_dat_o    (dat_o),
    .m_sel_o    (sel),
    .m_dat_i    (dat_i),
    .m_ack_i    (ack),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .timeout_o  (tmo),
    .err_cnt_o  (err),
    .fail_idx_o (fidx),
    .fail_rd_o  (frd),
    .fail_exp_o (fexp)
  );

  // Responder: registered ack after ws extra wait cycles, optional stuck-at-1 on bit 3 of word 5.
  always @(posedge clk) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (ack) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (cyc && stb && !never_ack) begin
      if (wcnt == ws) begin
        ack <= 1'b1;
        if (we) mem[adr[11:2]] <= dat_o;
        else    dat_i <= mem[adr[11:2]] | ((stuck && adr[11:2] == 10'd5) ? 32'h8 : 32'h0);
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] expv);
    n_vec++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] waddr(input int i);
    return 32'h3000_0000 + 32'(i) * 32'd4;
  endfunction

  task automatic note_read(input int i, input logic [31:0] rd, input logic [31:0] ex);
    if (rd != ex) begin
      if (e_err == 0) begin
        e_fidx = 10'(i);
        e_frd  = rd;
        e_fexp = ex;
      end
      e_err++;
    end
  endtask

  // Reference: the full March access list and the expected error summary.
  task automatic build_model(input logic [31:0] s, input bit flt);
    logic [31:0] p, f;
    exp_q.delete();
    e_err = 0; e_fidx = 10'd0; e_frd = 32'h0; e_fexp = 32'h0;
    for (int i = 0; i < 1024; i++) exp_q.push_back({1'b1, waddr(i), s ^ 32'(i)});
    for (int i = 0; i < 1024; i++) begin
      p = s ^ 32'(i);
      f = (flt && i == 5) ? 32'h8 : 32'h0;
      exp_q.push_back({1'b0, waddr(i), 32'h0});
      note_read(i, p | f, p);
      exp_q.push_back({1'b1, waddr(i), ~p});
    end
    for (int i = 1023; i >= 0; i--) begin
      p = ~(s ^ 32'(i));
      f = (flt && i == 5) ? 32'h8 : 32'h0;
      exp_q.push_back({1'b0, waddr(i), 32'h0});
      note_read(i, p | f, p);
    end
  endtask

  // Start a test, watch the bus every cycle until done_o or the budget runs out.
  task automatic run_test(input logic [31:0] s, input int poke, input int budget);
    int c, idle;
    bit fin, p_cyc, p_ack, p_we, have_prev;
    logic [64:0] p_bus;
    act_q.delete();
    busy_cycles = 0; cyc_high = 0; prot = 0;
    c = 0; idle = 0; fin = 0; p_cyc = 0; p_ack = 0; p_we = 0; have_prev = 0; p_bus = 65'h0;
    @(negedge clk); seed_i = s; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
    chk("start_err", err, 0);
    chk("start_tmo", tmo, 0);
    while (c < budget && !fin) begin
      if (busy) busy_cycles++;
      if (cyc) cyc_high++;
      if (cyc && stb) begin
        if (sel !== 4'hF) prot++;
        if (p_ack) prot++;
        if (p_cyc && !p_ack && {we, adr, dat_o} !== p_bus) prot++;
        if (!p_cyc && have_prev && (idle < 1 || idle > 2 || (p_we && idle != 1))) prot++;
      end
      if (cyc) idle = 0; else idle++;
      if (cyc && ack) begin
        act_q.push_back({we, adr, dat_o});
        have_prev = 1;
        p_we = we;
      end
      p_cyc = cyc;
      p_ack = cyc && ack;
      p_bus = {we, adr, dat_o};
      fin = done;
      start_i = (c == poke);
      if (!fin) begin
        @(negedge clk);
        c++;
      end
    end
    start_i = 1'b0;
    chk("run_finished", fin, 1);
  endtask

  task automatic check_run(input string tag);
    int n;
    chk({tag, "_acks"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_acc%0d", tag, i), act_q[i], exp_q[i]);
    chk({tag, "_protocol"}, prot, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_err"}, err, e_err);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start_i = 1'b0; seed_i = 32'h0;
    ws = 0; never_ack = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_err", err, 0);
    chk("rst_fidx", fidx, 0);
    chk("rst_frd", frd, 0);
    chk("rst_fexp", fexp, 0);
    rst_n = 1'b1;

    // Zero-wait ideal SRAM, fixed seed.
    build_model(32'hA5A5_0000, 1'b0);
    run_test(32'hA5A5_0000, -1, 20000);
    check_run("a");
    chk("a_pass", pass, 1);
    chk("a_acks_4096", act_q.size(), 4096);
    chk("a_busy_cycles", busy_cycles, 2048 * 3 + 2048 * 4);
    if (act_q.size() > 0) begin
      chk("a_first", act_q[0], {1'b1, 32'h3000_0000, 32'hA5A5_0000});
      chk("a_last", act_q[act_q.size() - 1], {1'b0, 32'h3000_0000, 32'h0});
    end else begin
      chk("a_nonempty", act_q.size(), 4096);
    end

    // Reset asserted mid-S1 with stb high.
    seed = $urandom();
    @(negedge clk); seed_i = seed; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    k = 0; nack = 0;
    while (k < 10000 && !(nack >= 1030 && cyc && stb)) begin
      if (cyc && ack) nack++;
      @(negedge clk);
      k++;
    end
    chk("e_reached_s1", (k < 10000), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("e_cyc", cyc, 0);
    chk("e_stb", stb, 0);
    chk("e_busy", busy, 0);
    chk("e_done", done, 0);
    chk("e_err", err, 0);
    chk("e_tmo", tmo, 0);
    rst_n = 1'b1;

    // Two wait states, start poked while busy.
    ws = 2;
    seed = $urandom();
    build_model(seed, 1'b0);
    run_test(seed, 500, 40000);
    check_run("c");
    chk("c_pass", pass, 1);
    chk("c_busy_cycles", busy_cycles, 2048 * 5 + 2048 * 6);

    // Stuck-at-1 on bit 3 of word 5, started from DONE.
    ws = 0; stuck = 1'b1;
    seed = $urandom() & 32'hFFFF_FFF7;
    build_model(seed, 1'b1);
    run_test(seed, -1, 20000);
    check_run("b");
    chk("b_pass", pass, 0);
    chk("b_err1", err, 1);
    chk("b_fidx", fidx, 5);
    chk("b_frd", frd, (seed ^ 32'd5) | 32'h8);
    chk("b_fexp", fexp, seed ^ 32'd5);
    chk("b_model_frd", frd, e_frd);

    // Responder never acks.
    stuck = 1'b0; never_ack = 1'b1;
    run_test($urandom(), -1, 600);
    chk("d_cyc_high", cyc_high, 255);
    chk("d_acks", act_q.size(), 0);
    chk("d_cyc", cyc, 0);
    chk("d_stb", stb, 0);
    chk("d_tmo", tmo, 1);
    chk("d_done", done, 1);
    chk("d_busy", busy, 0);
    chk("d_pass", pass, 0);
    chk("d_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
